// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder that sums WIDTH-bit operands CHUNK bits
// per clock through a ripple chain of half-adder-built full adders.
// Valid/ready handshake on both the operand and the result side.
// Optional feature: define OVF_EN to build the signed-overflow flag; without
// it, ovf is tied low and the port is kept.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry_reg;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic [CHUNK-1:0] cs;
    logic [CHUNK:0]   rc;
    logic [WIDTH-1:0] sum_next;
    logic             last_chunk;

    // Half-adder cell: returns {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    assign in_ready   = (state == IDLE) && !rst;
    assign last_chunk = (state == RUN) && (cnt == LAST);

    // Select the operand chunk addressed by the chunk counter
    always_comb begin
        ca = '0;
        cb = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                ca = a_r[i*CHUNK +: CHUNK];
                cb = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

    // Ripple chain: each full adder is two half adders plus an OR of carries
    always_comb begin
        logic [1:0] h1;
        logic [1:0] h2;
        h1    = '0;
        h2    = '0;
        cs    = '0;
        rc    = '0;
        rc[0] = carry_reg;
        for (int unsigned j = 0; j < CHUNK; j++) begin
            h1      = half_add(ca[j], cb[j]);
            h2      = half_add(h1[0], rc[j]);
            cs[j]   = h2[0];
            rc[j+1] = h1[1] | h2[1];
        end
    end

    // Merge the freshly computed chunk into the running sum
    always_comb begin
        sum_next = sum;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                sum_next[i*CHUNK +: CHUNK] = cs;
            end
        end
    end

    // Control FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry_reg <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r       <= a;
                        b_r       <= b;
                        carry_reg <= cin;
                        cnt       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum       <= sum_next;
                    carry_reg <= rc[CHUNK];
                    if (cnt == LAST) begin
                        cout      <= rc[CHUNK];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OVF_EN
    // Signed overflow from the latched operand signs and the final sum sign
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last_chunk) begin
            ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_next[WIDTH-1] != a_r[WIDTH-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: a 16/4 instance and an 8/8 instance, each with
// a transaction-level model checked every cycle, plus literal expectations.
module tb_seq_chunk_adder;

`ifdef OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit, 4-bit chunks
    logic        a_in_valid = 1'b0, a_in_ready, a_cin = 1'b0;
    logic [15:0] a_a = '0, a_b = '0, a_sum;
    logic        a_out_valid, a_out_ready = 1'b0, a_cout, a_ovf;
    // 8-bit, single chunk
    logic        b_in_valid = 1'b0, b_in_ready, b_cin = 1'b0;
    logic [7:0]  b_a = '0, b_b = '0, b_sum;
    logic        b_out_valid, b_out_ready = 1'b0, b_cout, b_ovf;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .a(a_a), .b(a_b), .cin(a_cin), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sum(a_sum), .cout(a_cout), .ovf(a_ovf)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .a(b_a), .b(b_b), .cin(b_cin), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sum(b_sum), .cout(b_cout), .ovf(b_ovf)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: result = plain integer sum, appears N+1 cycles after accept
    bit          ma_busy = 0, ma_valid = 0;
    int unsigned ma_wait = 0;
    logic [15:0] ma_sum = '0;
    logic        ma_cout = 0, ma_ovf = 0;
    bit          mb_busy = 0, mb_valid = 0;
    int unsigned mb_wait = 0;
    logic [7:0]  mb_sum = '0;
    logic        mb_cout = 0, mb_ovf = 0;

    always @(posedge clk) begin
        int          s;
        logic [16:0] t16;
        logic [8:0]  t8;
        if (rst) begin
            ma_busy = 0; ma_valid = 0; ma_sum = '0; ma_cout = 0; ma_ovf = 0;
        end else if (ma_busy) begin
            ma_wait--;
            if (ma_wait == 0) begin ma_busy = 0; ma_valid = 1; end
        end else if (ma_valid) begin
            if (a_out_ready) ma_valid = 0;
        end else if (a_in_valid) begin
            t16 = {1'b0, a_a} + {1'b0, a_b} + {16'b0, a_cin};
            s   = int'($signed(a_a)) + int'($signed(a_b)) + int'(a_cin);
            ma_sum = t16[15:0]; ma_cout = t16[16];
            ma_ovf = OVF && (s > 32767 || s < -32768);
            ma_busy = 1; ma_wait = 4;
        end

        if (rst) begin
            mb_busy = 0; mb_valid = 0; mb_sum = '0; mb_cout = 0; mb_ovf = 0;
        end else if (mb_busy) begin
            mb_wait--;
            if (mb_wait == 0) begin mb_busy = 0; mb_valid = 1; end
        end else if (mb_valid) begin
            if (b_out_ready) mb_valid = 0;
        end else if (b_in_valid) begin
            t8 = {1'b0, b_a} + {1'b0, b_b} + {8'b0, b_cin};
            s  = int'($signed(b_a)) + int'($signed(b_b)) + int'(b_cin);
            mb_sum = t8[7:0]; mb_cout = t8[8];
            mb_ovf = OVF && (s > 127 || s < -128);
            mb_busy = 1; mb_wait = 1;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        check("a_in_ready",  32'(a_in_ready),  32'(!rst && !ma_busy && !ma_valid));
        check("a_out_valid", 32'(a_out_valid), 32'(ma_valid));
        if (!ma_busy) begin
            check("a_sum",  32'(a_sum),  32'(ma_sum));
            check("a_cout", 32'(a_cout), 32'(ma_cout));
            check("a_ovf",  32'(a_ovf),  32'(ma_ovf));
        end
        check("b_in_ready",  32'(b_in_ready),  32'(!rst && !mb_busy && !mb_valid));
        check("b_out_valid", 32'(b_out_valid), 32'(mb_valid));
        if (!mb_busy) begin
            check("b_sum",  32'(b_sum),  32'(mb_sum));
            check("b_cout", 32'(b_cout), 32'(mb_cout));
            check("b_ovf",  32'(b_ovf),  32'(mb_ovf));
        end
    end

    task automatic run_a(input logic [15:0] x, input logic [15:0] y, input logic c,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input int unsigned hold, input bit early);
        int unsigned lat;
        bit ok;
        @(negedge clk);
        a_in_valid = 1; a_a = x; a_b = y; a_cin = c;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("a_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        // keep in_valid high with junk operands: must be ignored while busy
        a_a = 16'($urandom); a_b = 16'($urandom); a_cin = 1'($urandom);
        a_out_ready = early;
        lat = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (a_out_valid) begin ok = 1; break; end
        end
        a_in_valid = 0;
        check("a_valid_seen", 32'(ok), 32'd1);
        check("a_latency", lat, 32'd5);
        check("a_lit_sum", 32'(a_sum), 32'(es));
        check("a_lit_cout", 32'(a_cout), 32'(ec));
        check("a_lit_ovf", 32'(a_ovf), 32'(eo));
        if (!early) begin
            for (int unsigned h = 0; h < hold; h++) begin
                @(negedge clk);
                check("a_hold_valid", 32'(a_out_valid), 32'd1);
                check("a_hold_sum", 32'(a_sum), 32'(es));
                check("a_hold_ready", 32'(a_in_ready), 32'd0);
            end
            a_out_ready = 1;
        end
        @(posedge clk); #1;
        a_out_ready = 0;
        @(negedge clk);
        check("a_ready_after", 32'(a_in_ready), 32'd1);
        check("a_valid_after", 32'(a_out_valid), 32'd0);
    endtask

    task automatic run_b(input logic [7:0] x, input logic [7:0] y, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
        int unsigned lat;
        bit ok;
        @(negedge clk);
        b_in_valid = 1; b_a = x; b_b = y; b_cin = c;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (b_in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("b_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        b_in_valid = 0; b_a = 8'($urandom); b_b = 8'($urandom);
        lat = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (b_out_valid) begin ok = 1; break; end
        end
        check("b_valid_seen", 32'(ok), 32'd1);
        check("b_latency", lat, 32'd2);
        check("b_lit_sum", 32'(b_sum), 32'(es));
        check("b_lit_cout", 32'(b_cout), 32'(ec));
        check("b_lit_ovf", 32'(b_ovf), 32'(eo));
        b_out_ready = 1;
        @(posedge clk); #1;
        b_out_ready = 0;
        @(negedge clk);
        check("b_ready_after", 32'(b_in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sum", 32'(a_sum), 32'd0);
        check("rst_valid", 32'(a_out_valid), 32'd0);
        check("rst_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_ready", 32'(a_in_ready), 32'd1);

        // out_ready high while idle must not disturb anything
        a_out_ready = 1;
        repeat (2) @(negedge clk);
        a_out_ready = 0;

        run_a(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 0);
        run_a(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 1);
        run_a(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF, 3, 0);
        run_a(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, OVF, 1, 0);
        run_a(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0, 0);

        // reset in the middle of RUN drops the operation
        @(negedge clk);
        a_in_valid = 1; a_a = 16'h5555; a_b = 16'h1111; a_cin = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("midrst_ready", 32'(a_in_ready), 32'd1);
        check("midrst_sum", 32'(a_sum), 32'd0);
        check("midrst_cout", 32'(a_cout), 32'd0);
        check("midrst_ovf", 32'(a_ovf), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(a_out_valid), 32'd0);
        end
        run_a(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 0, 0);

        run_b(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OVF);
        run_b(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF);
        run_b(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
